// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states and the memory-map bases
// that the downstream address decoder uses.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    localparam logic [31:0] SRAM_BASE = 32'h8000_0000;
    localparam logic [31:0] UART_BASE = 32'h1000_0000;
    localparam logic [31:0] UART_LAST = 32'h1200_0000;
    localparam logic [31:0] SYS_LAST  = 32'h0000_FFFF;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog: cleared before each transfer, counts enabled cycles
// and flags expiry on the TIMEOUT-th cycle of the wait.
module apb_watchdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic pclk,
    input  logic presetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Saturates at the expiry value so a stalled enable cannot wrap around.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from the core valid/ready load/store port to an
// APB SETUP/ACCESS transfer, with a watchdog-bounded wait and a held response.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic                    req_write,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pdata,
    output logic                    pwrite,
    output logic [DATA_WIDTH/8-1:0] pstb,
    output logic                    psel,
    output logic                    penable,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    perr
);

    apb_state_t              r_state;
    logic                    r_reqReady;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_rspValid;
    logic                    r_rspErr;
    logic [DATA_WIDTH-1:0]   r_rspRdata;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_write;
    logic [DATA_WIDTH/8-1:0] r_strb;

    logic w_expire;
    logic w_timeout;
    logic w_done;

    apb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .pclk     (pclk),
        .presetn  (presetn),
        .i_clear  (r_state == SETUP),
        .i_enable (r_state == ACCESS),
        .o_expire (w_expire)
    );

    // Timeout only counts when the slave has not answered in the same cycle.
    assign w_timeout = w_expire && !pready && !perr;
    assign w_done    = pready || perr || w_timeout;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state    <= IDLE;
            r_reqReady <= 1'b1;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_strb     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_write    <= req_write;
                        r_strb     <= req_write ? req_strb : '0;
                        r_reqReady <= 1'b0;
                        r_psel     <= 1'b1;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_rspErr   <= perr || w_timeout;
                        r_rspRdata <= (!r_write && !perr && !w_timeout) ? prdata : '0;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_reqReady <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_reqReady;
    assign rsp_valid = r_rspValid;
    assign rsp_err   = r_rspErr;
    assign rsp_rdata = r_rspRdata;
    assign paddr     = r_addr;
    assign pdata     = r_wdata;
    assign pwrite    = r_write;
    assign pstb      = r_strb;
    assign psel      = r_psel;
    assign penable   = r_penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised bench for apb_master_bridge: a bench-side slave answers each
// transfer and a transaction-level model predicts length, error and data.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_write;
    logic [SW-1:0] req_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdata;
    logic          pwrite;
    logic [SW-1:0] pstb;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          perr;

    int errorCount = 0;
    int checkCount = 0;

    apb_master_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pdata     (pdata),
        .pwrite    (pwrite),
        .pstb      (pstb),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .perr      (perr)
    );

    always #5 pclk = ~pclk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete transaction: issue, act as slave, check response, hold, release.
    // waits >= TO means the slave never answers; errFlag gives perr only,
    // bothFlag gives pready and perr together on the first ACCESS cycle.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                                 input int waits, input bit errFlag, input bit bothFlag,
                                 input logic [DW-1:0] slaveData, input int holdCycles);
        int            expAccess;
        bit            expErr;
        logic [DW-1:0] expData;
        int            j;
        bit            done;

        if (errFlag || bothFlag) begin
            expAccess = 1;
            expErr    = 1'b1;
        end else if (waits < TO) begin
            expAccess = waits + 1;
            expErr    = 1'b0;
        end else begin
            expAccess = TO;
            expErr    = 1'b1;
        end
        expData = (!wr && !expErr) ? slaveData : '0;

        checkOutput("idle req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        @(posedge pclk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_strb  = SW'($urandom);

        checkOutput("setup psel/penable", {psel, penable}, 2'b10);
        checkOutput("setup req_ready", req_ready, 0);
        checkOutput("setup paddr", paddr, addr);
        checkOutput("setup pwrite", pwrite, wr);
        checkOutput("setup pstb", pstb, wr ? strb : '0);
        checkOutput("setup pdata", pdata, wdata);
        checkOutput("setup rsp_valid", rsp_valid, 0);
        @(posedge pclk); #1;

        j    = 0;
        done = 1'b0;
        while (!done && j < TO + 8) begin
            checkOutput("access psel/penable", {psel, penable}, 2'b11);
            checkOutput("access paddr", paddr, addr);
            checkOutput("access pstb", pstb, wr ? strb : '0);
            pready = (!errFlag && !bothFlag && j == waits) || (bothFlag && j == 0);
            perr   = (errFlag || bothFlag) && j == 0;
            prdata = pready ? slaveData : $urandom;
            @(posedge pclk); #1;
            pready = 1'b0;
            perr   = 1'b0;
            prdata = $urandom;
            j++;
            if (rsp_valid) done = 1'b1;
        end
        checkOutput("access cycle count", j, expAccess);
        checkOutput("resp rsp_err", rsp_err, expErr);
        checkOutput("resp rsp_rdata", rsp_rdata, expData);
        checkOutput("resp psel/penable", {psel, penable}, 2'b00);
        checkOutput("resp req_ready", req_ready, 0);

        // Core stalls the response while presenting a competing request.
        rsp_ready = 1'b0;
        for (int h = 0; h < holdCycles; h++) begin
            req_valid = 1'b1;
            req_addr  = $urandom;
            @(posedge pclk); #1;
            checkOutput("hold rsp_valid", rsp_valid, 1);
            checkOutput("hold rsp_err", rsp_err, expErr);
            checkOutput("hold rsp_rdata", rsp_rdata, expData);
            checkOutput("hold req_ready", req_ready, 0);
            checkOutput("hold psel", psel, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        checkOutput("release rsp_valid", rsp_valid, 0);
        checkOutput("release req_ready", req_ready, 1);
        checkOutput("release psel", psel, 0);
    endtask

    // Reset pulsed in the third ACCESS cycle of a never-answered read.
    task automatic resetMidTransfer();
        checkOutput("pre-reset req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h8000_0040;
        @(posedge pclk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #3;
        checkOutput("before reset psel/penable", {psel, penable}, 2'b11);
        presetn = 1'b0;
        #1;
        checkOutput("async reset psel", psel, 0);
        checkOutput("async reset penable", penable, 0);
        checkOutput("async reset rsp_valid", rsp_valid, 0);
        @(negedge pclk);
        presetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            checkOutput("post reset rsp_valid", rsp_valid, 0);
            checkOutput("post reset req_ready", req_ready, 1);
            checkOutput("post reset psel", psel, 0);
        end
    endtask

    // Directed test-plan items, then a randomised mix.
    initial begin
        logic [AW-1:0] addrPool [4];
        int            sel;
        int            waits;
        bit            errFlag;
        bit            bothFlag;

        addrPool[0] = apb_pkg::SRAM_BASE;
        addrPool[1] = apb_pkg::UART_BASE;
        addrPool[2] = 32'h2000_0000;
        addrPool[3] = 32'h0000_1000;

        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        req_strb  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        perr      = 1'b0;

        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;
        checkOutput("reset psel", psel, 0);
        checkOutput("reset penable", penable, 0);
        checkOutput("reset pwrite", pwrite, 0);
        checkOutput("reset pstb", pstb, 0);
        checkOutput("reset paddr", paddr, 0);
        checkOutput("reset pdata", pdata, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_err", rsp_err, 0);
        checkOutput("reset rsp_rdata", rsp_rdata, 0);
        checkOutput("reset req_ready", req_ready, 1);

        applyStimulus(1'b0, 32'h8000_0000, 32'h0, 4'hF, 2, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
        applyStimulus(1'b1, 32'h1000_0000, 32'h0000_0041, 4'b0001, 0, 1'b0, 1'b0, 32'h1234_5678, 0);
        applyStimulus(1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hCAFE_F00D, 0);
        applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'hF, TO, 1'b0, 1'b0, 32'h5555_AAAA, 1);
        applyStimulus(1'b1, 32'h1000_0004, 32'hA5A5_5A5A, 4'b1100, 0, 1'b0, 1'b0, 32'h0, 0);
        applyStimulus(1'b0, 32'h8000_0020, 32'h0, 4'hF, 0, 1'b0, 1'b1, 32'h7777_7777, 0);
        applyStimulus(1'b0, 32'h8000_0030, 32'h0, 4'hF, 1, 1'b0, 1'b0, 32'h0BAD_CAFE, 10);
        applyStimulus(1'b0, 32'h8000_0000, 32'h0, 4'hF, TO - 1, 1'b0, 1'b0, 32'h1357_9BDF, 0);

        resetMidTransfer();
        applyStimulus(1'b0, 32'h8000_0044, 32'h0, 4'hF, 1, 1'b0, 1'b0, 32'h2468_ACE0, 0);

        for (int n = 0; n < 24; n++) begin
            sel      = $urandom_range(0, 9);
            waits    = $urandom_range(0, 4);
            errFlag  = (sel == 0);
            bothFlag = (sel == 1);
            if (sel == 2) waits = TO;
            applyStimulus(1'($urandom), addrPool[$urandom_range(0, 3)], $urandom,
                          SW'($urandom), waits, errFlag, bothFlag, $urandom,
                          $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    // Global bound so a stuck handshake still terminates the run.
    initial begin
        #200000;
        $display("[TB] FAIL global timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errorCount + 1, checkCount + 1);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding bridge between the CPU load/store port and the APB bus. It sits directly upstream of the APB address decoder. It converts a valid/ready request into an APB SETUP/ACCESS transfer and waits for `pready` or `perr`. A watchdog bounds the wait. The result goes back to the core as a held response with read data and error flag.

## Interface
- `ADDR_WIDTH`, 32: APB/request address width.
- `DATA_WIDTH`, 32: data width; strobe is `DATA_WIDTH/8` bits.
- `TIMEOUT`, 1024: maximum ACCESS cycles before forced error; must be ≥1.

Clock and reset: one clock, `pclk`. Reset `presetn` is asynchronous and active-low.

- `pclk` in 1: bus clock, all state on rising edge.
- `presetn` in 1: async active-low reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: bridge can accept.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: write data.
- `req_write` in 1: 1 = write, 0 = read.
- `req_strb` in DATA_WIDTH/8: byte enables for writes.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: core consumes response.
- `rsp_rdata` out DATA_WIDTH: read data; 0 on write or error.
- `rsp_err` out 1: bus error or timeout.
- `paddr` out ADDR_WIDTH, `pdata` out DATA_WIDTH, `pwrite` out 1, `pstb` out 4, `psel` out 1, `penable` out 1: APB master outputs.
- `prdata` in DATA_WIDTH, `pready` in 1, `perr` in 1: APB returns from the decoder.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, capture addr, wdata, write and strb into holding registers, then go to SETUP.
  - `pstb` is forced to 0 for reads.
- SETUP: `psel=1`, `penable=0`, for exactly one cycle, then ACCESS.
- ACCESS:
  - `psel=1`, `penable=1`; the watchdog counter increments each cycle.
  - Complete on the first edge where `pready|perr|timeout`:
    - `rsp_err = perr | timeout`.
    - `rsp_rdata = prdata` if the transfer is a read and not an error, else 0.
  - Then go to RESP.
  - The decoder drives `perr=1` with `pready=0` on unmapped addresses, so `perr` alone terminates the transfer.
- Timeout: the counter is `$clog2(TIMEOUT+1)` bits, cleared on SETUP entry. It fires when the count equals `TIMEOUT-1` and `pready=0` and `perr=0`.
- RESP:
  - `psel=0`, `penable=0`, `rsp_valid=1`; rdata and err are held stable.
  - On `rsp_ready`, go to IDLE.
- `paddr`, `pdata`, `pwrite` and `pstb` are driven from the holding registers. They are stable from SETUP through the final ACCESS cycle.
- If `pready` and `perr` are both high, the transfer completes with `rsp_err=1` and `rsp_rdata=0`.
- Reset asserted in any state: the FSM returns to IDLE immediately. The in-flight transfer is dropped and no response is produced.

## Timing
- Reset values:
  - `psel`, `penable`, `pwrite`, `pstb`, `paddr`, `pdata` = 0.
  - `rsp_valid`, `rsp_err`, `rsp_rdata` = 0.
  - `req_ready` = 1 once `presetn` is high.
- Accept at edge N gives SETUP in cycle N+1 and ACCESS from N+2.
- With zero wait states, `rsp_valid` rises in N+3. Each wait cycle adds 1.
- `rsp_valid` is a registered output, held until `rsp_ready`. Leaving RESP at edge M gives `req_ready=1` in cycle M+1.
- Minimum request-to-request spacing is 4 cycles.
- Only one transfer is outstanding; `req_ready=0` in SETUP, ACCESS and RESP.

## Structure
- Shared package `apb_pkg`:
  - the `apb_state_t` enum (IDLE, SETUP, ACCESS, RESP);
  - the memory-map base constants used by the decoder (`SRAM_BASE` 0x80000000, `UART_BASE` 0x10000000, `UART_LAST` 0x12000000, `SYS_LAST` 0xFFFF).
- One sub-module, `apb_watchdog`, holds the clear/enable/expire counter parameterised by `TIMEOUT`.

## Test plan
- Read 0x80000000; slave returns 0xDEADBEEF with `pready` after 2 wait states.
  - Expected: `rsp_valid` at N+5 with rdata 0xDEADBEEF and err 0.
  - Expected: `paddr` stable through SETUP/ACCESS.
- Write 0x10000000, wdata 0x00000041, strb 4'b0001, zero wait.
  - Expected: `pwrite=1` and `pstb=0001` on the bus, `penable` high one cycle.
  - Expected: response rdata 0, err 0 at N+3.
- Read 0x20000000 (unmapped); decoder gives `perr=1`, `pready=0`.
  - Expected: completes after one ACCESS cycle with `rsp_err=1`, `rsp_rdata=0`.
- `TIMEOUT=16`, `pready` and `perr` held low.
  - Expected: exactly 16 ACCESS cycles, then `rsp_err=1`; a new request is accepted after `rsp_ready`.
- `presetn` pulsed low during the 3rd ACCESS cycle.
  - Expected: `psel`, `penable` and `rsp_valid` fall asynchronously, with no response.
  - Expected: the next request proceeds normally.
- `rsp_ready` held low for 10 cycles after completion.
  - Expected: `rsp_valid`, rdata and err are stable, `req_ready=0`, and `req_valid` is ignored until release.
